proc_out_serializer: RTL and testbench



---
 rtl/proc_out_serializer_pkg.sv | 50 +++++
 rtl/proc_out_serializer_if.sv | 28 ++
 rtl/proc_out_serializer_out_col_picker.sv | 23 ++
 rtl/proc_out_serializer.sv | 88 ++++++++
 tb/tb_proc_out_serializer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/proc_out_serializer_pkg.sv
// Shared types, sizes and the column keep-mask helper for proc_out_serializer.
// Sizes mirror the processing engine parameters.
package proc_out_serializer_pkg;

    localparam int COLS           = 4;
    localparam int ROWS           = 2;
    localparam int WORD_WIDTH_OUT = 16;
    localparam int KW_MAX         = 7;
    localparam int SW_MAX         = 4;

    localparam int KW2_W = $clog2(KW_MAX / 2 + 1);
    localparam int SW1_W = $clog2(SW_MAX);
    localparam int COL_W = $clog2(COLS);

    typedef struct packed {
        logic             is_config;
        logic [KW2_W-1:0] kw2;
        logic [SW1_W-1:0] sw_1;
    } tuser_st;

    typedef logic [WORD_WIDTH_OUT-1:0] word_t;
    typedef word_t [ROWS-1:0]          col_t;
    typedef col_t [COLS-1:0]           beat_t;
    typedef logic [COL_W-1:0]          col_idx_t;
    typedef logic [COLS-1:0]           keep_mask_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } ser_state_e;

    // Column c is kept when c mod (2*kw2 + sw_1 + 1) < sw_1 + 1; the modulo is
    // tracked as a wrapping counter so no divider is built.
    function automatic keep_mask_t out_keep_mask(input logic [KW2_W-1:0] kw2,
                                                 input logic [SW1_W-1:0] sw_1);
        keep_mask_t  mask;
        logic [31:0] s;
        logic [31:0] j;
        logic [31:0] pos;
        s   = 32'(sw_1) + 32'd1;
        j   = 32'd2 * 32'(kw2) + 32'(sw_1) + 32'd1;
        pos = 32'd0;
        for (int c = 0; c < COLS; c++) begin
            mask[c] = (pos < s);
            pos     = (pos + 32'd1 == j) ? 32'd0 : pos + 32'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/proc_out_serializer_if.sv
// Wide-in / narrow-out AXI-Stream bundle around proc_out_serializer.
// The serializer takes the slave modport; the surrounding environment takes master.
interface proc_out_serializer_if;
    import proc_out_serializer_pkg::*;

    logic     s_ready;
    logic     s_valid;
    logic     s_last;
    beat_t    s_data;
    tuser_st  s_user;
    logic     m_ready;
    logic     m_valid;
    logic     m_last;
    col_t     m_data;
    tuser_st  m_user;
    col_idx_t m_col;

    modport slave (
        output s_ready, m_valid, m_last, m_data, m_user, m_col,
        input  s_valid, s_last, s_data, s_user, m_ready
    );

    modport master (
        input  s_ready, m_valid, m_last, m_data, m_user, m_col,
        output s_valid, s_last, s_data, s_user, m_ready
    );

endinterface

// File: rtl/proc_out_serializer_out_col_picker.sv
// Finds the next kept column above the current one and flags when none is left.
module out_col_picker
    import proc_out_serializer_pkg::*;
(
    input  keep_mask_t mask_i,
    input  col_idx_t   col_i,
    output col_idx_t   next_col_o,
    output logic       is_last_kept_o
);

    // Scanning downward lets the lowest kept column above col_i win.
    always_comb begin
        next_col_o     = col_i;
        is_last_kept_o = 1'b1;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (mask_i[c] && (c > int'(col_i))) begin
                next_col_o     = col_idx_t'(c);
                is_last_kept_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/proc_out_serializer.sv
// Serializes one wide accumulator beat into per-column narrow beats, dropping config beats.
// Define PROC_OUT_KEEP_FILTER_EN to also drop columns outside the kernel/stride keep mask.
module proc_out_serializer
    import proc_out_serializer_pkg::*;
(
    input logic                  clk,
    input logic                  resetn,
    proc_out_serializer_if.slave bus
);

    ser_state_e state_q, state_d;
    beat_t      hold_data_q, hold_data_d;
    tuser_st    hold_user_q, hold_user_d;
    logic       hold_last_q, hold_last_d;
    col_idx_t   col_q, col_d;

    keep_mask_t keep_mask;
    col_idx_t   next_col;
    logic       is_last_kept;
    logic       s_ready;
    logic       accept;

`ifdef PROC_OUT_KEEP_FILTER_EN
    assign keep_mask = out_keep_mask(hold_user_q.kw2, hold_user_q.sw_1);
`else
    assign keep_mask = '1;
`endif

    out_col_picker u_picker (
        .mask_i         (keep_mask),
        .col_i          (col_q),
        .next_col_o     (next_col),
        .is_last_kept_o (is_last_kept)
    );

    assign s_ready = (state_q == ST_IDLE) || (bus.m_ready && is_last_kept);
    assign accept  = bus.s_valid && s_ready;

    // Column 0 is always kept, so a freshly loaded beat always starts there.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_user_d = hold_user_q;
        hold_last_d = hold_last_q;
        col_d       = col_q;
        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                if (bus.m_ready) begin
                    if (is_last_kept) state_d = ST_IDLE;
                    else              col_d   = next_col;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && !bus.s_user.is_config) begin
            state_d     = ST_SHIFT;
            hold_data_d = bus.s_data;
            hold_user_d = bus.s_user;
            hold_last_d = bus.s_last;
            col_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            hold_data_q <= '0;
            hold_user_q <= '0;
            hold_last_q <= 1'b0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_user_q <= hold_user_d;
            hold_last_q <= hold_last_d;
            col_q       <= col_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = (state_q == ST_SHIFT);
    assign bus.m_data  = hold_data_q[col_q];
    assign bus.m_user  = hold_user_q;
    assign bus.m_col   = col_q;
    assign bus.m_last  = (state_q == ST_SHIFT) && hold_last_q && is_last_kept;

endmodule

// File: tb/tb_proc_out_serializer.sv
// Self-checking bench for proc_out_serializer: directed scenarios plus random traffic
// against a queue model of the expected narrow beats (follows PROC_OUT_KEEP_FILTER_EN).
module tb_proc_out_serializer;
    import proc_out_serializer_pkg::*;

    typedef struct {
        col_t     data;
        col_idx_t col;
        tuser_st  user;
        logic     last;
    } exp_col_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    proc_out_serializer_if bus ();

    proc_out_serializer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    exp_col_t expQ[$];
    int       nAsserts = 0;
    int       nFails   = 0;
    logic     expSReady;
    logic     acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic keep_mask_t refMask(input tuser_st u);
        keep_mask_t m;
`ifdef PROC_OUT_KEEP_FILTER_EN
        int k;
        int s;
        int j;
        k = 2 * int'(u.kw2) + 1;
        s = int'(u.sw_1) + 1;
        j = k + s - 1;
        for (int c = 0; c < COLS; c++) m[c] = ((c % j) < s);
`else
        m = '1;
`endif
        return m;
    endfunction

    function automatic void modelAccept(input beat_t d, input tuser_st u, input logic l);
        keep_mask_t m;
        int         hi;
        exp_col_t   e;
        if (u.is_config) return;
        m  = refMask(u);
        hi = 0;
        for (int c = 0; c < COLS; c++) if (m[c]) hi = c;
        for (int c = 0; c < COLS; c++) begin
            if (m[c]) begin
                e.data = d[c];
                e.col  = col_idx_t'(c);
                e.user = u;
                e.last = l && (c == hi);
                expQ.push_back(e);
            end
        end
    endfunction

    task automatic checkOutput(input logic mr);
        expSReady = (expQ.size() == 0) || (expQ.size() == 1 && mr);
        check("s_ready", 64'(bus.s_ready), 64'(expSReady));
        check("m_valid", 64'(bus.m_valid), 64'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            check("m_data", 64'(bus.m_data), 64'(expQ[0].data));
            check("m_col",  64'(bus.m_col),  64'(expQ[0].col));
            check("m_user", 64'(bus.m_user), 64'(expQ[0].user));
            check("m_last", 64'(bus.m_last), 64'(expQ[0].last));
        end
    endtask

    task automatic applyStimulus(input logic sv, input beat_t d, input tuser_st u,
                                 input logic l, input logic mr, output logic accepted);
        @(posedge clk);
        #1;
        bus.s_valid = sv;
        bus.s_data  = d;
        bus.s_user  = u;
        bus.s_last  = l;
        bus.m_ready = mr;
        @(negedge clk);
        checkOutput(mr);
        accepted = sv && expSReady;
        if (expQ.size() != 0 && mr) void'(expQ.pop_front());
        if (accepted) modelAccept(d, u, l);
    endtask

    task automatic idle(input logic mr);
        logic a;
        applyStimulus(1'b0, '0, '0, 1'b0, mr, a);
    endtask

    task automatic sendUntilAccepted(input beat_t d, input tuser_st u, input logic l);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) applyStimulus(1'b1, d, u, l, 1'b1, a);
        if (!a) begin
            nAsserts++;
            nFails++;
            $error("[TB] FAIL accept_timeout: observed 0 expected 1");
        end
    endtask

    function automatic beat_t planBeat();
        beat_t d;
        for (int c = 0; c < COLS; c++) begin
            d[c][1] = word_t'(10 * c + 1);
            d[c][0] = word_t'(10 * c);
        end
        return d;
    endfunction

    function automatic beat_t randBeat();
        beat_t d;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) d[c][r] = word_t'($urandom);
        return d;
    endfunction

    function automatic tuser_st mkUser(input int kw2, input int sw1, input logic cfg);
        tuser_st u;
        u.is_config = cfg;
        u.kw2       = KW2_W'(kw2);
        u.sw_1      = SW1_W'(sw1);
        return u;
    endfunction

    initial begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
        bus.s_user  = '0;
        bus.m_ready = 1'b0;

        $display("[TB] reset values");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_last",  64'(bus.m_last),  64'd0);
        check("rst_m_data",  64'(bus.m_data),  64'd0);
        check("rst_m_user",  64'(bus.m_user),  64'd0);
        check("rst_m_col",   64'(bus.m_col),   64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        $display("[TB] kernel/stride beat kw2=1 sw_1=0");
        applyStimulus(1'b1, planBeat(), mkUser(1, 0, 1'b0), 1'b1, 1'b1, acc);
        repeat (6) idle(1'b1);

        $display("[TB] config beat drop");
        applyStimulus(1'b1, randBeat(), mkUser(2, 1, 1'b1), 1'b1, 1'b1, acc);
        repeat (3) idle(1'b1);

        $display("[TB] back-to-back beats");
        sendUntilAccepted(randBeat(), mkUser(0, 0, 1'b0), 1'b0);
        sendUntilAccepted(randBeat(), mkUser(0, 0, 1'b0), 1'b1);
        repeat (6) idle(1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, planBeat(), mkUser(0, 0, 1'b0), 1'b1, 1'b1, acc);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        repeat (6) idle(1'b1);

        $display("[TB] reset mid-shift");
        applyStimulus(1'b1, randBeat(), mkUser(0, 0, 1'b0), 1'b1, 1'b1, acc);
        idle(1'b1);
        idle(1'b1);
        resetn = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        check("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("mid_rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("mid_rst_m_col",   64'(bus.m_col),   64'd0);
        resetn = 1'b1;
        applyStimulus(1'b1, planBeat(), mkUser(1, 1, 1'b0), 1'b1, 1'b1, acc);
        repeat (6) idle(1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randBeat(),
                          mkUser(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                 1'($urandom_range(0, 5) == 0)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), acc);
        end
        repeat (12) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
